xga_sync_gen: RTL and testbench

XGA (1024x768 @ 60 Hz) display timing generator for the display IP. Runs on the 65 MHz pixel clock, counts pixels and lines, and drives the active-low XGA_HS/XGA_VS sync pulses, the display-enable window and aligned pixel/line coordinates to the pixel pipeline and the VGA output pins. Its XGA_VS output is the signal sampled by the VBLANK flag logic on the bus side. Run/stop is controlled by DISP_ON and takes effect only on frame boundaries.

---
 rtl/xga_sync_gen.sv | 122 ++++++++++++
 tb/tb_xga_sync_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/xga_sync_gen.sv
// rtl/xga_sync_gen.sv - XGA display timing generator (sync pulses, display enable, coordinates)
module xga_sync_gen #(
  parameter int HACT = 1024,
  parameter int HFP  = 24,
  parameter int HSW  = 136,
  parameter int HBP  = 160,
  parameter int VACT = 768,
  parameter int VFP  = 3,
  parameter int VSW  = 6,
  parameter int VBP  = 29
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        DISP_ON,
  output logic        XGA_HS,
  output logic        XGA_VS,
  output logic        DISP_EN,
  output logic [10:0] HCNT,
  output logic [9:0]  VCNT,
  output logic        FRAME_START,
  output logic        LINE_REQ
);

  localparam int HTOTAL = HACT + HFP + HSW + HBP;
  localparam int VTOTAL = VACT + VFP + VSW + VBP;

  // Counter widths are fixed; reject timings that would overflow them.
  generate
    if (HTOTAL > 2048 || VTOTAL > 1024) begin : g_bad_timing
      $error("xga_sync_gen: HTOTAL must be <= 2048 and VTOTAL <= 1024");
    end
  endgenerate

  localparam logic [10:0] H_LAST     = 11'(HTOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(HACT);
  localparam logic [10:0] H_SYNC_BEG = 11'(HACT + HFP);
  localparam logic [10:0] H_SYNC_END = 11'(HACT + HFP + HSW);
  localparam logic [9:0]  V_LAST     = 10'(VTOTAL - 1);
  localparam logic [9:0]  V_ACT      = 10'(VACT);
  localparam logic [9:0]  V_ACT_LAST = 10'(VACT - 1);
  localparam logic [9:0]  V_SYNC_BEG = 10'(VACT + VFP);
  localparam logic [9:0]  V_SYNC_END = 10'(VACT + VFP + VSW);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state;
  logic [10:0] h;
  logic [9:0]  v;

  logic run;
  logic en_d;
  logic hs_d;
  logic vs_d;
  logic fs_d;
  logic lr_d;

  // Run/stop control and pixel/line counters; stopping is only honoured at frame end.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state <= S_IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          h <= '0;
          v <= '0;
          if (DISP_ON) state <= S_RUN;
        end
        S_RUN: begin
          if (h == H_LAST) begin
            h <= '0;
            if (v == V_LAST) begin
              v <= '0;
              if (!DISP_ON) state <= S_IDLE;
            end else begin
              v <= v + 10'd1;
            end
          end else begin
            h <= h + 11'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          h     <= '0;
          v     <= '0;
        end
      endcase
    end
  end

  assign run  = (state == S_RUN);
  assign en_d = run && (h < H_ACT) && (v < V_ACT);
  assign hs_d = !(run && (h >= H_SYNC_BEG) && (h < H_SYNC_END));
  assign vs_d = !(run && (v >= V_SYNC_BEG) && (v < V_SYNC_END));
  assign fs_d = run && (h == 11'd0) && (v == 10'd0);
  // Prefetch fires during the sync region of the line before each active line,
  // including the last blanking line ahead of line 0.
  assign lr_d = run && (h == H_SYNC_BEG) && ((v < V_ACT_LAST) || (v == V_LAST));

  // Register all decodes and coordinates from the same (h, v) so outputs stay aligned.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      XGA_HS      <= 1'b1;
      XGA_VS      <= 1'b1;
      DISP_EN     <= 1'b0;
      HCNT        <= '0;
      VCNT        <= '0;
      FRAME_START <= 1'b0;
      LINE_REQ    <= 1'b0;
    end else begin
      XGA_HS      <= hs_d;
      XGA_VS      <= vs_d;
      DISP_EN     <= en_d;
      HCNT        <= h;
      VCNT        <= v;
      FRAME_START <= fs_d;
      LINE_REQ    <= lr_d;
    end
  end

endmodule

// File: tb/tb_xga_sync_gen.sv
// tb/tb_xga_sync_gen.sv - scoreboard bench for xga_sync_gen on a reduced timing
module tb_xga_sync_gen;

  localparam int HACT = 16;
  localparam int HFP  = 4;
  localparam int HSW  = 6;
  localparam int HBP  = 6;
  localparam int VACT = 12;
  localparam int VFP  = 2;
  localparam int VSW  = 3;
  localparam int VBP  = 3;
  localparam int HT   = HACT + HFP + HSW + HBP;
  localparam int VT   = VACT + VFP + VSW + VBP;

  localparam logic [25:0] RESET_VEC = {5'b11000, 11'd0, 10'd0};

  logic        ACLK;
  logic        ARST;
  logic        DISP_ON;
  logic        XGA_HS;
  logic        XGA_VS;
  logic        DISP_EN;
  logic [10:0] HCNT;
  logic [9:0]  VCNT;
  logic        FRAME_START;
  logic        LINE_REQ;

  xga_sync_gen #(
    .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP)
  ) dut (
    .ACLK(ACLK),
    .ARST(ARST),
    .DISP_ON(DISP_ON),
    .XGA_HS(XGA_HS),
    .XGA_VS(XGA_VS),
    .DISP_EN(DISP_EN),
    .HCNT(HCNT),
    .VCNT(VCNT),
    .FRAME_START(FRAME_START),
    .LINE_REQ(LINE_REQ)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [25:0] exp_q[$];

  // reference model of the internal state
  bit ms_run = 0;
  int mh = 0;
  int mv = 0;

  // observation bookkeeping
  int  cyc = 0;
  int  fs_seen = 0;
  int  fs_period = 0;
  int  last_fs_period = -1;
  bit  stats_arm = 0;
  int  per_cnt = 0;
  int  en_cnt = 0;
  int  hs_low = 0;
  int  vs_low = 0;
  int  lr_cnt = 0;
  logic prev_hs = 1'b1;
  logic prev_vs = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [25:0] model_vec();
    logic hs, vs, en, fs, lr;
    hs = !(ms_run && mh >= HACT + HFP && mh < HACT + HFP + HSW);
    vs = !(ms_run && mv >= VACT + VFP && mv < VACT + VFP + VSW);
    en = ms_run && mh < HACT && mv < VACT;
    fs = ms_run && mh == 0 && mv == 0;
    lr = ms_run && mh == HACT + HFP && (mv < VACT - 1 || mv == VT - 1);
    return {hs, vs, en, fs, lr, 11'(mh), 10'(mv)};
  endfunction

  task automatic model_step(input logic d, input logic r);
    if (r) begin
      ms_run = 0; mh = 0; mv = 0;
    end else if (!ms_run) begin
      mh = 0; mv = 0;
      if (d) ms_run = 1;
    end else if (mh == HT - 1) begin
      mh = 0;
      if (mv == VT - 1) begin
        mv = 0;
        if (!d) ms_run = 0;
      end else begin
        mv = mv + 1;
      end
    end else begin
      mh = mh + 1;
    end
  endtask

  task automatic frame_stats();
    per_cnt++;
    if (DISP_EN) en_cnt++;
    if (!XGA_HS) hs_low++;
    if (!XGA_VS) vs_low++;
    if (LINE_REQ) lr_cnt++;
    if (prev_hs && !XGA_HS) check_eq("hs_fall_h", 32'(HCNT), 32'(HACT + HFP));
    if (prev_vs && !XGA_VS) begin
      check_eq("vs_fall_h", 32'(HCNT), 32'd0);
      check_eq("vs_fall_v", 32'(VCNT), 32'(VACT + VFP));
    end
    prev_hs = XGA_HS;
    prev_vs = XGA_VS;
  endtask

  // One clock: drive inputs for the current period, push the expected output, compare.
  task automatic cycle(input logic d, input logic r);
    logic [25:0] exp_v;
    DISP_ON = d;
    ARST    = r;
    @(posedge ACLK);
    exp_q.push_back(r ? RESET_VEC : model_vec());
    model_step(d, r);
    cyc++;
    #1;
    exp_v = exp_q.pop_front();
    check_eq("outputs", 32'({XGA_HS, XGA_VS, DISP_EN, FRAME_START, LINE_REQ, HCNT, VCNT}), 32'(exp_v));
    if (r) stats_arm = 0;
    if (FRAME_START) begin
      fs_seen++;
      if (stats_arm) begin
        check_eq("frame_period", 32'(per_cnt), 32'(HT * VT));
        check_eq("en_per_frame", 32'(en_cnt), 32'(HACT * VACT));
        check_eq("hs_low_per_frame", 32'(hs_low), 32'(HSW * VT));
        check_eq("vs_low_per_frame", 32'(vs_low), 32'(VSW * HT));
        check_eq("lr_per_frame", 32'(lr_cnt), 32'(VACT));
      end
      stats_arm = 1;
      per_cnt = 0; en_cnt = 0; hs_low = 0; vs_low = 0; lr_cnt = 0;
    end
    frame_stats();
  endtask

  task automatic wait_pos(input string tag, input int vv, input int hh, input logic d, input int bound);
    int n;
    n = 0;
    while (!(VCNT == 10'(vv) && HCNT == 11'(hh)) && n < bound) begin
      cycle(d, 1'b0);
      n++;
    end
    check_eq(tag, 32'(n < bound), 32'd1);
  endtask

  initial begin
    int on_cyc;
    int n;
    DISP_ON = 1'b0;
    ARST    = 1'b1;

    // reset and hold idle
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0);
    check_eq("idle_hs", 32'(XGA_HS), 32'd1);
    check_eq("idle_vs", 32'(XGA_VS), 32'd1);
    check_eq("idle_cnt", 32'({HCNT, VCNT}), 32'd0);

    // start: FRAME_START two periods after DISP_ON is applied
    on_cyc = cyc;
    cycle(1'b1, 1'b0);
    n = 0;
    while (!FRAME_START && n < 10) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    check_eq("start_latency", 32'(cyc - on_cyc), 32'd2);
    check_eq("start_en", 32'(DISP_EN), 32'd1);

    // two complete frames of continuous running
    n = 0;
    while (fs_seen < 3 && n < 3 * HT * VT) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    check_eq("two_frames_done", 32'(fs_seen), 32'd3);

    // drop mid-frame, briefly re-raise, drop again: frame must complete then go idle
    wait_pos("reach_v8", 8, 0, 1'b1, HT * VT);
    for (int i = 0; i < 2 * HT; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    wait_pos("reach_frame_end", VT - 1, HT - 1, 1'b0, HT * VT);
    cycle(1'b0, 1'b0);
    check_eq("frame_end_wrap_fs", 32'(FRAME_START), 32'd0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0);
    check_eq("stopped_en", 32'(DISP_EN), 32'd0);
    check_eq("stopped_cnt", 32'({HCNT, VCNT}), 32'd0);

    // restart, reset while VS is low
    stats_arm = 0;
    cycle(1'b1, 1'b0);
    wait_pos("reach_vs_low", VACT + VFP, 10, 1'b1, 2 * HT * VT);
    check_eq("vs_low_before_rst", 32'(XGA_VS), 32'd0);
    cycle(1'b1, 1'b1);
    check_eq("rst_vs", 32'(XGA_VS), 32'd1);
    check_eq("rst_cnt", 32'({HCNT, VCNT}), 32'd0);
    cycle(1'b1, 1'b0);
    check_eq("rst_fs_early", 32'(FRAME_START), 32'd0);
    cycle(1'b1, 1'b0);
    check_eq("rst_fs_restart", 32'(FRAME_START), 32'd1);
    for (int i = 0; i < 2 * HT; i++) cycle(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
